// File: rtl/cmd_saver_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ht_cmd_pkg                                                   |
// | Purpose : Shared constants and FSM state type for the CMD file saver   |
// |           and loader: record type codes, maximum load block size and   |
// |           the saver state enumeration.                                 |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ht_cmd_pkg;

  // Record type bytes that open each CMD record
  localparam logic [7:0] REC_LOAD = 8'h01;
  localparam logic [7:0] REC_XFER = 8'h02;

  // Largest payload a single load record may carry
  localparam int unsigned MAX_BLOCK = 256;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REC_TYPE = 4'd1,
    REC_LEN  = 4'd2,
    REC_ALO  = 4'd3,
    REC_AHI  = 4'd4,
    MEM_REQ  = 4'd5,
    MEM_WAIT = 4'd6,
    DATA     = 4'd7,
    XFR_TYPE = 4'd8,
    XFR_LEN  = 4'd9,
    XFR_LO   = 4'd10,
    XFR_HI   = 4'd11
  } state_e;

endpackage : ht_cmd_pkg
`default_nettype wire

// File: rtl/cmd_saver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cmd_saver                                                    |
// | Purpose : Streams a RAM address range out as a CMD file: a sequence of |
// |           load records (at most 256 data bytes each) followed by one   |
// |           transfer record carrying the entry point.                    |
// | Ports   : clock/reset      - system clock, sync active-high reset      |
// |           start, *_addr    - command pulse and latched address range   |
// |           mem_rd/addr/data - RAM read port, data 1 cycle after mem_rd  |
// |           out_*            - valid/ready byte stream, out_last on end  |
// |           busy/done/err    - status; byte_count counts accepted bytes  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module cmd_saver
  import ht_cmd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] exec_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [16:0] byte_count
);

  localparam logic [16:0] BLOCK17 = 17'(MAX_BLOCK);

  state_e      state_q, state_d;
  logic [15:0] cursor_q;
  logic [15:0] exec_q;
  logic [16:0] remain_q;    // bytes still to send; 17 bits so 0x10000 fits
  logic [8:0]  rec_left_q;  // bytes still to send in the current record
  logic [7:0]  hold_q;
  logic        err_q;
  logic        done_q;
  logic [16:0] count_q;

  logic        accept;
  logic        start_ok;
  logic        range_bad;
  logic [16:0] range_len;
  logic [8:0]  blk_n;
  logic [7:0]  len_byte;

  assign accept    = out_valid & out_ready;
  assign start_ok  = start & (state_q == IDLE);
  assign range_bad = end_addr < start_addr;
  assign range_len = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;

  // Payload of the record about to start: min(256, remaining)
  assign blk_n    = (remain_q > BLOCK17) ? 9'(MAX_BLOCK) : remain_q[8:0];
  // LEN is (n + 2) mod 256; the 8-bit add wraps naturally
  assign len_byte = blk_n[7:0] + 8'd2;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = range_bad ? XFR_TYPE : REC_TYPE;
      REC_TYPE: if (accept) state_d = REC_LEN;
      REC_LEN:  if (accept) state_d = REC_ALO;
      REC_ALO:  if (accept) state_d = REC_AHI;
      REC_AHI:  if (accept) state_d = MEM_REQ;
      MEM_REQ:  state_d = MEM_WAIT;
      MEM_WAIT: state_d = DATA;
      DATA: begin
        if (accept) begin
          if (remain_q == 17'd1)        state_d = XFR_TYPE;
          else if (rec_left_q == 9'd1)  state_d = REC_TYPE;
          else                          state_d = MEM_REQ;
        end
      end
      XFR_TYPE: if (accept) state_d = XFR_LEN;
      XFR_LEN:  if (accept) state_d = XFR_LO;
      XFR_LO:   if (accept) state_d = XFR_HI;
      XFR_HI:   if (accept) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    mem_rd    = 1'b0;
    unique case (state_q)
      REC_TYPE: begin out_valid = 1'b1; out_data = REC_LOAD;        end
      REC_LEN:  begin out_valid = 1'b1; out_data = len_byte;        end
      REC_ALO:  begin out_valid = 1'b1; out_data = cursor_q[7:0];   end
      REC_AHI:  begin out_valid = 1'b1; out_data = cursor_q[15:8];  end
      MEM_REQ:  mem_rd = 1'b1;
      DATA:     begin out_valid = 1'b1; out_data = hold_q;          end
      XFR_TYPE: begin out_valid = 1'b1; out_data = REC_XFER;        end
      XFR_LEN:  begin out_valid = 1'b1; out_data = 8'h02;           end
      XFR_LO:   begin out_valid = 1'b1; out_data = exec_q[7:0];     end
      XFR_HI: begin
        out_valid = 1'b1;
        out_data  = exec_q[15:8];
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      cursor_q   <= 16'h0000;
      exec_q     <= 16'h0000;
      remain_q   <= 17'd0;
      rec_left_q <= 9'd0;
      hold_q     <= 8'h00;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 17'd0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        cursor_q <= start_addr;
        exec_q   <= exec_addr;
        remain_q <= range_bad ? 17'd0 : range_len;
        err_q    <= range_bad;
        count_q  <= 17'd0;
      end else if (accept) begin
        count_q <= count_q + 17'd1;
      end

      if (state_q == REC_LEN && accept) begin
        rec_left_q <= blk_n;
      end

      if (state_q == MEM_WAIT) begin
        hold_q <= mem_data;
      end

      if (state_q == DATA && accept) begin
        remain_q   <= remain_q - 17'd1;
        rec_left_q <= rec_left_q - 9'd1;
        // Hold the cursor on the final byte so 0xFFFF never wraps to 0x0000
        if (remain_q != 17'd1) begin
          cursor_q <= cursor_q + 16'd1;
        end
      end

      if (state_q == XFR_HI && accept) begin
        done_q <= 1'b1;
      end
    end
  end

  assign mem_addr   = cursor_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = count_q;

endmodule : cmd_saver
`default_nettype wire

// File: doc/cmd_saver.md
CMD_SAVER -- requirements
Module: cmd_saver

Interface
REQ-001 clock  in  1  system clock (42 MHz clk_sys domain).
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begin a save when idle.
REQ-004 start_addr  in  16  first RAM address to save, inclusive.
REQ-005 end_addr  in  16  last RAM address to save, inclusive.
REQ-006 exec_addr  in  16  entry point written to the transfer record.
REQ-007 mem_rd  out  1  RAM read strobe, one cycle.
REQ-008 mem_addr  out  16  RAM read address.
REQ-009 mem_data  in  8  RAM read data, valid exactly 1 cycle after mem_rd.
REQ-010 out_valid  out  1  out_data holds a valid CMD byte.
REQ-011 out_data  out  8  CMD file byte stream.
REQ-012 out_ready  in  1  sink accepts the byte when out_valid && out_ready.
REQ-013 out_last  out  1  high with the final byte of the file.
REQ-014 busy  out  1  save in progress.
REQ-015 done  out  1  one-cycle pulse after the last byte is accepted.
REQ-016 err  out  1  end_addr < start_addr on the latched start; stays set until the next start.
REQ-017 byte_count  out  17  bytes accepted so far in the current file.

Function
REQ-018 start while idle SHALL latch all three addresses; start while busy is ignored.
REQ-019 The file SHALL be load records, then exactly one transfer record.
REQ-020 Load record SHALL be: 0x01, LEN, addr_lo, addr_hi, then n data bytes; n = 1..256.
REQ-021 LEN SHALL be (n+2) mod 256; n = 256 gives 0x02, n = 254 gives 0x00.
REQ-022 Each record SHALL carry min(256, remaining) bytes; the cursor advances by n.
REQ-023 Transfer record SHALL be 0x02, 0x02, exec_lo, exec_hi; out_last is high on exec_hi.
REQ-024 FSM states SHALL be: IDLE, REC_TYPE, REC_LEN, REC_ALO, REC_AHI, MEM_REQ, MEM_WAIT, DATA, XFR_TYPE, XFR_LEN, XFR_LO, XFR_HI.
REQ-025 MEM_REQ SHALL assert mem_rd for one cycle with mem_addr = cursor.
REQ-026 MEM_WAIT SHALL capture mem_data into a holding register.
REQ-027 DATA SHALL present the held byte; on acceptance the FSM goes to MEM_REQ, or to REC_TYPE / XFR_TYPE when the record or range ends.
REQ-028 Header and trailer states SHALL advance only on acceptance; out_data and out_valid stay stable while out_ready is low.
REQ-029 out_valid SHALL be low in IDLE, MEM_REQ and MEM_WAIT.
REQ-030 Each data byte SHALL cost at most 3 cycles at out_ready = 1; no mem_rd is issued while a byte is pending.
REQ-031 Remaining count SHALL be 17 bits; end_addr = 0xFFFF SHALL terminate without cursor wrap to 0x0000.
REQ-032 err SHALL suppress all load records; the file is the transfer record only (4 bytes).
REQ-033 done SHALL pulse one cycle after the XFR_HI acceptance; busy drops in the same cycle.
REQ-034 byte_count SHALL increment on every acceptance and clear on an accepted start.

Reset
REQ-035 reset SHALL force IDLE at any point, including mid-record, with no further bytes or mem_rd.
REQ-036 Reset values SHALL be: out_valid, out_last, mem_rd, busy, done, err = 0; out_data, mem_addr, byte_count = 0.

Structure
REQ-037 Package ht_cmd_pkg SHALL hold: record type constants (0x01 load, 0x02 transfer), the 256-byte max block constant, and the FSM state enum.
REQ-038 cmd_loader SHALL import the same package.
REQ-039 Single module, no sub-module; block size is a localparam from the package.

Verification
REQ-040 Single byte: start=end=0x5200 holding 0xAA, exec 0x5200, out_ready=1 -> 01 03 00 52 AA 02 02 00 52; done pulses; byte_count = 9.
REQ-041 Block split: range 0x5200..0x5300 -> 01 02 00 52 + 256 bytes, then 01 03 00 53 + 1 byte, then 02 02 lo hi; 269 bytes total.
REQ-042 Full range: 0x0000..0xFFFF -> 256 records of LEN 0x02; final address 0xFFFF; no wrap; byte_count = 66564.
REQ-043 Backpressure: random out_ready on REQ-041 -> identical stream; out_data stable while stalled; mem_rd count = 257.
REQ-044 Error: start 0x6000, end 0x5FFF, exec 0x1234 -> err = 1; stream is 02 02 34 12; done pulses.
REQ-045 Reset mid-op: reset during the DATA state of REQ-041 -> next cycle out_valid = 0, busy = 0, mem_rd = 0; a later start produces a correct full stream.
